// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word over a load handshake and
// streams it one bit per transfer on a valid/ready serial port, flagging the last bit.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next, shifted;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             out_reg, out_next;
    logic             valid_reg, valid_next;
    logic             last_reg, last_next;
    logic             bit_xfer;
    logic             load;

    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            out_reg   <= 1'b0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        bit_xfer   = valid_reg & ser_ready;
        // A word can be taken while idle or in the same cycle the previous last bit leaves.
        load_ready = (state_reg == IDLE) | (bit_xfer & last_reg);
        load       = load_valid & load_ready;
        shifted    = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        valid_next = valid_reg;
        last_next  = last_reg;

        if (load) begin
            state_next = SHIFT;
            shift_next = parin;
            cnt_next   = CW'(WIDTH - 1);
            out_next   = first_bit(parin);
            valid_next = 1'b1;
            last_next  = (WIDTH == 1);
        end else if (bit_xfer) begin
            if (last_reg) begin
                state_next = IDLE;
                shift_next = '0;
                cnt_next   = '0;
                out_next   = 1'b0;
                valid_next = 1'b0;
                last_next  = 1'b0;
            end else begin
                shift_next = shifted;
                cnt_next   = cnt_reg - CW'(1);
                out_next   = first_bit(shifted);
                last_next  = (cnt_reg == CW'(1));
            end
        end
    end

    assign ser_out   = out_reg;
    assign ser_valid = valid_reg;
    assign ser_last  = last_reg;
    assign busy      = valid_reg;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage placed directly downstream of the 4-bit parallel holding register. It accepts a parallel word through a valid/ready load handshake and shifts it out one bit per transfer on a serial valid/ready interface. It flags the last bit of each word. Back-to-back words stream with no idle cycle between them.

## Interface
- WIDTH, 4: bits per word; legal range 1 to 32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on clk.
- parin  input  WIDTH  parallel word, driven from the holding register outputs (Q3..Q0 at WIDTH=4).
- load_valid  input  1  parin holds a word to be serialized.
- load_ready  output  1  block can accept a word on this edge (combinational).
- ser_out  output  1  current serial bit (registered).
- ser_valid  output  1  ser_out carries a valid bit (registered).
- ser_last  output  1  current bit is the final bit of its word (registered).
- ser_ready  input  1  downstream consumes ser_out on this edge.
- busy  output  1  equals ser_valid; provided for status and debug.

## Operation
- States: IDLE (no word held) and SHIFT (word being sent).
- Internal registers:
  - shift register, WIDTH bits.
  - bit counter, ceil(log2(WIDTH)) bits, minimum 1.
- Reset, while reset is low: state=IDLE, shift register=0, counter=0, ser_out=0, ser_valid=0, ser_last=0.
  - Any load_valid or ser_ready activity is ignored.
  - A word in flight is discarded and is not resumed after reset is released.
- Definitions:
  - bit_xfer = ser_valid & ser_ready.
  - load_ready = (state==IDLE) | (bit_xfer & ser_last).
  - load = load_valid & load_ready.
- On load: capture parin, go to SHIFT, set counter=WIDTH-1.
  - Drive ser_out with the first bit: parin[WIDTH-1] if MSB_FIRST, else parin[0].
  - Set ser_valid=1 and ser_last=(WIDTH==1).
- In SHIFT on bit_xfer with ser_last=0: shift the register toward the output end, decrement the counter, present the next bit. ser_last=1 when the counter reaches 0.
- In SHIFT on bit_xfer with ser_last=1:
  - With load: the new word's first bit is presented on the next cycle, with no bubble.
  - Without load: go to IDLE, ser_valid=0, ser_last=0, ser_out=0.
- If ser_ready=0: ser_out, ser_valid, ser_last, the shift register and the counter all hold.
- load_valid asserted while load_ready=0 is ignored. parin may change freely mid-word without affecting the word being sent.
- Once ser_valid is asserted it must not drop until the bit is transferred.
- WIDTH=1: every bit is a last bit; ser_last=1 whenever ser_valid=1.

## Timing
- Load latency: a word accepted at edge N puts its first bit on ser_out after edge N.
- Throughput: one bit per cycle while ser_ready=1.
- A WIDTH-bit word occupies exactly WIDTH transfer cycles. Sustained streaming reaches 100% ser_valid duty.
- load_ready is combinational on ser_ready and state only; there is no path from load_valid to load_ready.
- ser_valid falls on the edge after the last transfer when no new load occurs in that cycle.

## Test plan
- Reset: hold reset low for 3 cycles, then release → all outputs 0 and load_ready=1. Assert reset asynchronously in the middle of bit 2 → ser_valid=0 immediately and the word is discarded.
- Single word: WIDTH=4, MSB_FIRST=1, parin=4'b1011, ser_ready=1 → ser_out is 1,0,1,1 on 4 consecutive cycles, ser_last=1 only on the 4th, ser_valid=0 on cycle 5.
- Stall: same word with ser_ready=0 for 3 cycles while bit 2 (0) is presented → ser_out=0, ser_valid=1 and ser_last=0 hold for those cycles, then the sequence resumes with 1,1.
- Back-to-back: load 4'b1011, then 4'b0110 on the last-bit transfer → 8 consecutive valid bits 1,0,1,1,0,1,1,0, with ser_last on bits 4 and 8.
- Ignored load: assert load_valid with parin=4'hF during bits 1–3 of word 4'b0001 → load_ready=0 and output stays 0,0,0,1. The 4'hF word is accepted only at the last-bit transfer.
- LSB first: MSB_FIRST=0, parin=4'b1011 → ser_out is 1,1,0,1. WIDTH=1, parin=1 → one bit with ser_last=1.
